ysyx_24070016_wbu: RTL and testbench

- Writeback stage directly upstream of the register file. Consumes completed instructions from EXU/LSU through a valid/ready handshake.
- Selects and aligns the result, registers it for one cycle, then drives the register file write port (rf_wen/rf_waddr/rf_wdata).
- Owns a per-register pending-write scoreboard. IDU uses it for RAW hazard checks and issue throttling.

---
 rtl/ysyx_24070016_pkg.sv | 24 ++
 rtl/ysyx_24070016_load_align.sv | 29 ++
 rtl/ysyx_24070016_wbu.sv | 201 ++++++++++++++++++++
 tb/tb_ysyx_24070016_wbu.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_24070016_pkg.sv
// Shared constants and types for the ysyx_24070016 writeback stage.
package ysyx_24070016_pkg;

   // Result source select encodings
   localparam logic [1:0] WB_SEL_ALU  = 2'd0;
   localparam logic [1:0] WB_SEL_LOAD = 2'd1;
   localparam logic [1:0] WB_SEL_PC4  = 2'd2;
   localparam logic [1:0] WB_SEL_CSR  = 2'd3;

   // Load funct3 encodings
   localparam logic [2:0] LOAD_LB  = 3'b000;
   localparam logic [2:0] LOAD_LH  = 3'b001;
   localparam logic [2:0] LOAD_LW  = 3'b010;
   localparam logic [2:0] LOAD_LBU = 3'b100;
   localparam logic [2:0] LOAD_LHU = 3'b101;

   // Payload held in the stage register alongside its destination index
   typedef struct packed {
      logic        wen;
      logic [31:0] data;
      logic [31:0] pc;
   } wb_stage_t;

endpackage

// File: rtl/ysyx_24070016_load_align.sv
// Load data alignment: extracts the addressed byte/half from a raw aligned
// word and sign- or zero-extends it according to funct3. Combinational.
module ysyx_24070016_load_align
   import ysyx_24070016_pkg::*;
(
   input  logic [31:0] ldata,
   input  logic [2:0]  funct3,
   input  logic [1:0]  addr_lo,
   output logic [31:0] aligned
);

   logic [7:0]  byte_v;
   logic [15:0] half_v;

   // Lane selection then extension; halfword ignores address bit 0
   always_comb begin
      byte_v = ldata[{addr_lo, 3'b000} +: 8];
      half_v = ldata[{addr_lo[1], 4'b0000} +: 16];
      case (funct3)
         LOAD_LB:  aligned = {{24{byte_v[7]}}, byte_v};
         LOAD_LH:  aligned = {{16{half_v[15]}}, half_v};
         LOAD_LW:  aligned = ldata;
         LOAD_LBU: aligned = {24'h000000, byte_v};
         LOAD_LHU: aligned = {16'h0000, half_v};
         default:  aligned = ldata;
      endcase
   end

endmodule

// File: rtl/ysyx_24070016_wbu.sv
// Writeback unit: selects/aligns the result, stages it for one cycle, drives
// the register file write port and keeps a per-register pending-write
// scoreboard for issue hazard checks.
// Optional feature macro: YSYX_24070016_WBU_PERF_EN adds perf_retired and
// perf_idle 64-bit counters.
module ysyx_24070016_wbu
   import ysyx_24070016_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 5,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned SB_CNT_W   = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [ADDR_WIDTH-1:0] in_rd,
   input  logic                  in_wen,
   input  logic [1:0]            in_sel,
   input  logic [DATA_WIDTH-1:0] in_pc,
   input  logic [DATA_WIDTH-1:0] in_alu,
   input  logic [DATA_WIDTH-1:0] in_csr,
   input  logic [DATA_WIDTH-1:0] in_ldata,
   input  logic [2:0]            in_lfunct3,
   input  logic [1:0]            in_addr_lo,
   input  logic                  iss_valid,
   output logic                  iss_ready,
   input  logic [ADDR_WIDTH-1:0] iss_rd,
   input  logic                  iss_wen,
   input  logic [ADDR_WIDTH-1:0] q_rs1,
   input  logic [ADDR_WIDTH-1:0] q_rs2,
   output logic                  q_busy1,
   output logic                  q_busy2,
   output logic                  rf_wen,
   output logic [ADDR_WIDTH-1:0] rf_waddr,
   output logic [DATA_WIDTH-1:0] rf_wdata,
   output logic                  retire_valid,
   output logic [DATA_WIDTH-1:0] retire_pc,
   output logic                  sb_err
`ifdef YSYX_24070016_WBU_PERF_EN
   ,
   output logic [63:0]           perf_retired,
   output logic [63:0]           perf_idle
`endif
);

   localparam int unsigned         NUM_REGS = 1 << ADDR_WIDTH;
   localparam logic [SB_CNT_W-1:0] CNT_MAX  = {SB_CNT_W{1'b1}};
   localparam logic [SB_CNT_W-1:0] CNT_ONE  = SB_CNT_W'(1);
   localparam logic [SB_CNT_W-1:0] CNT_ZERO = {SB_CNT_W{1'b0}};
   localparam logic [ADDR_WIDTH-1:0] RD_ZERO = {ADDR_WIDTH{1'b0}};

   logic                  xfer;
   logic [DATA_WIDTH-1:0] load_val;
   logic [DATA_WIDTH-1:0] result;

   logic                  stage_valid_q, stage_valid_d;
   logic [ADDR_WIDTH-1:0] stage_rd_q, stage_rd_d;
   wb_stage_t             stage_q, stage_d;

   logic [SB_CNT_W-1:0]   cnt_q [NUM_REGS];
   logic [SB_CNT_W-1:0]   cnt_d [NUM_REGS];
   logic                  sb_err_q, sb_err_d;
   logic                  sb_inc;
   logic                  sb_dec;

   ysyx_24070016_load_align u_load_align (
      .ldata   (in_ldata),
      .funct3  (in_lfunct3),
      .addr_lo (in_addr_lo),
      .aligned (load_val)
   );

   // Handshake: the register file never stalls, so accept whenever out of reset
   always_comb begin
      in_ready = !rst;
      xfer     = in_valid & !rst;
   end

   // Result source select ahead of the stage register
   always_comb begin
      case (in_sel)
         WB_SEL_ALU:  result = in_alu;
         WB_SEL_LOAD: result = load_val;
         WB_SEL_PC4:  result = in_pc + DATA_WIDTH'(32'd4);
         WB_SEL_CSR:  result = in_csr;
         default:     result = in_alu;
      endcase
   end

   // Stage next state: load payload on a transfer, valid tracks the transfer
   always_comb begin
      stage_valid_d = xfer;
      stage_rd_d    = stage_rd_q;
      stage_d       = stage_q;
      if (xfer) begin
         stage_rd_d   = in_rd;
         stage_d.wen  = in_wen;
         stage_d.data = result;
         stage_d.pc   = in_pc;
      end else begin
         stage_rd_d   = stage_rd_q;
         stage_d      = stage_q;
      end
   end

   // Stage register
   always_ff @(posedge clk) begin
      if (rst) begin
         stage_valid_q <= 1'b0;
         stage_rd_q    <= RD_ZERO;
         stage_q       <= '0;
      end else begin
         stage_valid_q <= stage_valid_d;
         stage_rd_q    <= stage_rd_d;
         stage_q       <= stage_d;
      end
   end

   assign rf_wen       = stage_valid_q & stage_q.wen & (stage_rd_q != RD_ZERO);
   assign rf_waddr     = stage_rd_q;
   assign rf_wdata     = stage_q.data;
   assign retire_valid = stage_valid_q;
   assign retire_pc    = stage_q.pc;
   assign sb_err       = sb_err_q;

   // Issue throttle and hazard queries; a same-cycle retire to the full
   // register frees a slot, but busy reflects only the registered count
   always_comb begin
      iss_ready = !(iss_wen && (iss_rd != RD_ZERO) && (cnt_q[iss_rd] == CNT_MAX)
                    && !(rf_wen && (stage_rd_q == iss_rd)));
      q_busy1   = (q_rs1 != RD_ZERO) && (cnt_q[q_rs1] != CNT_ZERO);
      q_busy2   = (q_rs2 != RD_ZERO) && (cnt_q[q_rs2] != CNT_ZERO);
   end

   // Scoreboard next state: per-register inc on issue, dec on writeback
   always_comb begin
      sb_inc   = iss_valid & iss_ready & iss_wen & (iss_rd != RD_ZERO);
      sb_dec   = rf_wen;
      sb_err_d = sb_err_q | (sb_dec & (cnt_q[stage_rd_q] == CNT_ZERO));
      cnt_d[0] = CNT_ZERO;
      for (int unsigned r = 1; r < NUM_REGS; r++) begin
         if (sb_inc && (iss_rd == ADDR_WIDTH'(r)) &&
             !(sb_dec && (stage_rd_q == ADDR_WIDTH'(r)))) begin
            cnt_d[r] = cnt_q[r] + CNT_ONE;
         end else if (sb_dec && (stage_rd_q == ADDR_WIDTH'(r)) &&
                      !(sb_inc && (iss_rd == ADDR_WIDTH'(r))) &&
                      (cnt_q[r] != CNT_ZERO)) begin
            cnt_d[r] = cnt_q[r] - CNT_ONE;
         end else begin
            cnt_d[r] = cnt_q[r];
         end
      end
   end

   // Scoreboard counters and sticky underflow flag
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned r = 0; r < NUM_REGS; r++) begin
            cnt_q[r] <= CNT_ZERO;
         end
         sb_err_q <= 1'b0;
      end else begin
         for (int unsigned r = 0; r < NUM_REGS; r++) begin
            cnt_q[r] <= cnt_d[r];
         end
         sb_err_q <= sb_err_d;
      end
   end

`ifdef YSYX_24070016_WBU_PERF_EN
   logic [63:0] perf_retired_q, perf_retired_d;
   logic [63:0] perf_idle_q, perf_idle_d;

   // Performance counter next state: retire cycles vs. empty-stage cycles
   always_comb begin
      perf_retired_d = perf_retired_q;
      perf_idle_d    = perf_idle_q;
      if (stage_valid_q) begin
         perf_retired_d = perf_retired_q + 64'd1;
      end else begin
         perf_idle_d    = perf_idle_q + 64'd1;
      end
   end

   // Performance counter registers
   always_ff @(posedge clk) begin
      if (rst) begin
         perf_retired_q <= 64'd0;
         perf_idle_q    <= 64'd0;
      end else begin
         perf_retired_q <= perf_retired_d;
         perf_idle_q    <= perf_idle_d;
      end
   end

   assign perf_retired = perf_retired_q;
   assign perf_idle    = perf_idle_q;
`endif

endmodule

// File: tb/tb_ysyx_24070016_wbu.sv
// Self-checking bench for ysyx_24070016_wbu: table-driven datapath vectors
// plus directed scoreboard, underflow and reset sequences.
module tb_ysyx_24070016_wbu;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [4:0]  in_rd;
   logic        in_wen;
   logic [1:0]  in_sel;
   logic [31:0] in_pc;
   logic [31:0] in_alu;
   logic [31:0] in_csr;
   logic [31:0] in_ldata;
   logic [2:0]  in_lfunct3;
   logic [1:0]  in_addr_lo;
   logic        iss_valid;
   logic        iss_ready;
   logic [4:0]  iss_rd;
   logic        iss_wen;
   logic [4:0]  q_rs1;
   logic [4:0]  q_rs2;
   logic        q_busy1;
   logic        q_busy2;
   logic        rf_wen;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;
   logic        retire_valid;
   logic [31:0] retire_pc;
   logic        sb_err;
`ifdef YSYX_24070016_WBU_PERF_EN
   logic [63:0] perf_retired;
   logic [63:0] perf_idle;
`endif

   int checks;
   int errors;

   ysyx_24070016_wbu dut (
      .clk          (clk),
      .rst          (rst),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_rd        (in_rd),
      .in_wen       (in_wen),
      .in_sel       (in_sel),
      .in_pc        (in_pc),
      .in_alu       (in_alu),
      .in_csr       (in_csr),
      .in_ldata     (in_ldata),
      .in_lfunct3   (in_lfunct3),
      .in_addr_lo   (in_addr_lo),
      .iss_valid    (iss_valid),
      .iss_ready    (iss_ready),
      .iss_rd       (iss_rd),
      .iss_wen      (iss_wen),
      .q_rs1        (q_rs1),
      .q_rs2        (q_rs2),
      .q_busy1      (q_busy1),
      .q_busy2      (q_busy2),
      .rf_wen       (rf_wen),
      .rf_waddr     (rf_waddr),
      .rf_wdata     (rf_wdata),
      .retire_valid (retire_valid),
      .retire_pc    (retire_pc),
      .sb_err       (sb_err)
`ifdef YSYX_24070016_WBU_PERF_EN
      ,
      .perf_retired (perf_retired),
      .perf_idle    (perf_idle)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  sel;
      logic [4:0]  rd;
      logic        wen;
      logic [31:0] pc;
      logic [31:0] alu;
      logic [31:0] csr;
      logic [2:0]  f3;
      logic [1:0]  alo;
      logic        exp_wen;
      logic [31:0] exp_data;
   } vec_t;

   vec_t vecs [14];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [4:0] rd, input logic wen, input logic [31:0] alu);
      in_valid = 1'b1;
      in_rd    = rd;
      in_wen   = wen;
      in_sel   = 2'd0;
      in_alu   = alu;
      in_pc    = 32'h0000_2000;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst = 1'b1;
      in_valid = 1'b0; in_rd = 5'd0; in_wen = 1'b0; in_sel = 2'd0;
      in_pc = 32'd0; in_alu = 32'd0; in_csr = 32'd0;
      in_ldata = 32'h8091_A2B3; in_lfunct3 = 3'd0; in_addr_lo = 2'd0;
      iss_valid = 1'b0; iss_rd = 5'd0; iss_wen = 1'b0;
      q_rs1 = 5'd7; q_rs2 = 5'd0;

      //             sel   rd     wen   pc             alu            csr            f3      alo   ewen  edata
      vecs[0]  = '{2'd0, 5'd5,  1'b1, 32'h0000_1000, 32'hDEAD_BEEF, 32'h0BAD_F00D, 3'b000, 2'd0, 1'b1, 32'hDEAD_BEEF};
      vecs[1]  = '{2'd1, 5'd3,  1'b1, 32'h0000_1004, 32'hA5A5_A5A5, 32'h0BAD_F00D, 3'b000, 2'd1, 1'b1, 32'hFFFF_FFA2};
      vecs[2]  = '{2'd1, 5'd4,  1'b1, 32'h0000_1008, 32'hA5A5_A5A5, 32'h0BAD_F00D, 3'b100, 2'd3, 1'b1, 32'h0000_0080};
      vecs[3]  = '{2'd1, 5'd6,  1'b1, 32'h0000_100C, 32'hA5A5_A5A5, 32'h0BAD_F00D, 3'b001, 2'd2, 1'b1, 32'hFFFF_8091};
      vecs[4]  = '{2'd1, 5'd8,  1'b1, 32'h0000_1010, 32'hA5A5_A5A5, 32'h0BAD_F00D, 3'b101, 2'd0, 1'b1, 32'h0000_A2B3};
      vecs[5]  = '{2'd1, 5'd11, 1'b1, 32'h0000_1014, 32'hA5A5_A5A5, 32'h0BAD_F00D, 3'b001, 2'd3, 1'b1, 32'hFFFF_8091};
      vecs[6]  = '{2'd1, 5'd12, 1'b1, 32'h0000_1018, 32'hA5A5_A5A5, 32'h0BAD_F00D, 3'b010, 2'd2, 1'b1, 32'h8091_A2B3};
      vecs[7]  = '{2'd1, 5'd13, 1'b1, 32'h0000_101C, 32'hA5A5_A5A5, 32'h0BAD_F00D, 3'b011, 2'd1, 1'b1, 32'h8091_A2B3};
      vecs[8]  = '{2'd1, 5'd14, 1'b1, 32'h0000_1020, 32'hA5A5_A5A5, 32'h0BAD_F00D, 3'b000, 2'd0, 1'b1, 32'hFFFF_FFB3};
      vecs[9]  = '{2'd1, 5'd15, 1'b1, 32'h0000_1024, 32'hA5A5_A5A5, 32'h0BAD_F00D, 3'b101, 2'd2, 1'b1, 32'h0000_8091};
      vecs[10] = '{2'd2, 5'd1,  1'b1, 32'hFFFF_FFFC, 32'hA5A5_A5A5, 32'h0BAD_F00D, 3'b000, 2'd0, 1'b1, 32'h0000_0000};
      vecs[11] = '{2'd3, 5'd31, 1'b1, 32'h0000_1030, 32'hA5A5_A5A5, 32'h1234_5678, 3'b000, 2'd0, 1'b1, 32'h1234_5678};
      vecs[12] = '{2'd2, 5'd0,  1'b1, 32'h8000_0000, 32'hA5A5_A5A5, 32'h0BAD_F00D, 3'b000, 2'd0, 1'b0, 32'h8000_0004};
      vecs[13] = '{2'd0, 5'd10, 1'b0, 32'h0000_1038, 32'h0000_0055, 32'h0BAD_F00D, 3'b000, 2'd0, 1'b0, 32'h0000_0055};

      // Reset state
      #1;
      chk("in_ready_in_reset", 64'(in_ready), 64'd0);
      tick();
      tick();
      chk("rst_rf_wen", 64'(rf_wen), 64'd0);
      chk("rst_retire_valid", 64'(retire_valid), 64'd0);
      chk("rst_rf_waddr", 64'(rf_waddr), 64'd0);
      chk("rst_rf_wdata", 64'(rf_wdata), 64'd0);
      chk("rst_retire_pc", 64'(retire_pc), 64'd0);
      chk("rst_sb_err", 64'(sb_err), 64'd0);
      chk("rst_q_busy1", 64'(q_busy1), 64'd0);
      rst = 1'b0;
      #1;
      chk("in_ready_out_of_reset", 64'(in_ready), 64'd1);

      // Datapath vectors, back to back
      for (int i = 0; i < 14; i++) begin
         in_valid   = 1'b1;
         in_sel     = vecs[i].sel;
         in_rd      = vecs[i].rd;
         in_wen     = vecs[i].wen;
         in_pc      = vecs[i].pc;
         in_alu     = vecs[i].alu;
         in_csr     = vecs[i].csr;
         in_lfunct3 = vecs[i].f3;
         in_addr_lo = vecs[i].alo;
         tick();
         chk($sformatf("vec%0d_rf_wen", i), 64'(rf_wen), 64'(vecs[i].exp_wen));
         chk($sformatf("vec%0d_rf_waddr", i), 64'(rf_waddr), 64'(vecs[i].rd));
         chk($sformatf("vec%0d_rf_wdata", i), 64'(rf_wdata), 64'(vecs[i].exp_data));
         chk($sformatf("vec%0d_retire_valid", i), 64'(retire_valid), 64'd1);
         chk($sformatf("vec%0d_retire_pc", i), 64'(retire_pc), 64'(vecs[i].pc));
      end
      in_valid = 1'b0;
      tick();
      chk("drain_rf_wen", 64'(rf_wen), 64'd0);
      chk("drain_retire_valid", 64'(retire_valid), 64'd0);

      // Fresh reset for the scoreboard sequences
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("sb_err_cleared", 64'(sb_err), 64'd0);

      // Three issues to x7 fill a 2-bit counter
      iss_valid = 1'b1; iss_wen = 1'b1; iss_rd = 5'd7;
      for (int k = 0; k < 3; k++) begin
         #1;
         chk($sformatf("issue%0d_ready", k), 64'(iss_ready), 64'd1);
         tick();
      end
      q_rs1 = 5'd7; q_rs2 = 5'd8;
      #1;
      chk("busy1_x7", 64'(q_busy1), 64'd1);
      chk("busy2_x8", 64'(q_busy2), 64'd0);
      chk("issue4_blocked", 64'(iss_ready), 64'd0);
      iss_rd = 5'd0;
      #1;
      chk("issue_x0_ready", 64'(iss_ready), 64'd1);
      iss_rd = 5'd7; iss_wen = 1'b0;
      #1;
      chk("issue_nowen_ready", 64'(iss_ready), 64'd1);
      iss_wen = 1'b1;
      iss_valid = 1'b0;

      // Writeback x7 while a fourth issue to x7 is presented
      send(5'd7, 1'b1, 32'h0000_0077);
      tick();
      in_valid = 1'b0;
      iss_valid = 1'b1;
      #1;
      chk("wb7_rf_wen", 64'(rf_wen), 64'd1);
      chk("issue4_with_wb_ready", 64'(iss_ready), 64'd1);
      tick();
      chk("cnt7_still_full", 64'(iss_ready), 64'd0);
      iss_valid = 1'b0;

      // Drain x7 with three writebacks
      send(5'd7, 1'b1, 32'h0000_0077);
      tick();
      tick();
      chk("drain7_busy_mid", 64'(q_busy1), 64'd1);
      tick();
      in_valid = 1'b0;
      tick();
      chk("drain7_busy_done", 64'(q_busy1), 64'd0);
      chk("drain7_no_err", 64'(sb_err), 64'd0);

      // x0 writeback retires but neither writes nor touches the scoreboard
      send(5'd0, 1'b1, 32'h0000_0123);
      tick();
      in_valid = 1'b0;
      chk("x0_rf_wen", 64'(rf_wen), 64'd0);
      chk("x0_retire", 64'(retire_valid), 64'd1);
      tick();
      chk("x0_no_err", 64'(sb_err), 64'd0);

      // Underflow on x9 sets a sticky error
      send(5'd9, 1'b1, 32'h0000_0009);
      tick();
      in_valid = 1'b0;
      chk("uf_err_not_yet", 64'(sb_err), 64'd0);
      tick();
      chk("uf_err_set", 64'(sb_err), 64'd1);
      q_rs2 = 5'd9;
      #1;
      chk("uf_busy9", 64'(q_busy2), 64'd0);
      tick();
      tick();
      chk("uf_err_sticky", 64'(sb_err), 64'd1);

      // Reset with a staged result discards it
      send(5'd12, 1'b1, 32'h0000_00AA);
      tick();
      in_valid = 1'b0;
      chk("midrst_staged", 64'(rf_wen), 64'd1);
      rst = 1'b1;
      tick();
      chk("midrst_rf_wen", 64'(rf_wen), 64'd0);
      chk("midrst_retire", 64'(retire_valid), 64'd0);
      chk("midrst_err_clr", 64'(sb_err), 64'd0);
      rst = 1'b0;

`ifdef YSYX_24070016_WBU_PERF_EN
      // Three idle cycles, then ten back-to-back transfers
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tick();
      tick();
      tick();
      send(5'd0, 1'b1, 32'h0000_0001);
      for (int k = 0; k < 10; k++) begin
         tick();
      end
      in_valid = 1'b0;
      tick();
      chk("perf_retired", perf_retired, 64'd10);
      chk("perf_idle", perf_idle, 64'd4);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
